// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one memory op in flight, aligned store lanes, req/resp memory port.
// Optional ADDR_EXC_EN adds misaligned-access detection (out_adel_ades) that skips the memory port.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_opcode,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [31:0]           in_rt,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [3:0]            data_wstrb,
    output logic [31:0]           data_wdata,
    input  logic                  data_addr_ok,
    input  logic [31:0]           data_rdata,
    input  logic                  data_data_ok,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            out_opcode,
    output logic [1:0]            out_ea,
    output logic [31:0]           out_regdata,
`ifdef ADDR_EXC_EN
    output logic                  out_adel_ades,
`endif
    output logic [31:0]           out_loaddata
);

    localparam logic [5:0] OpLb  = 6'd32;
    localparam logic [5:0] OpLh  = 6'd33;
    localparam logic [5:0] OpLwl = 6'd34;
    localparam logic [5:0] OpLw  = 6'd35;
    localparam logic [5:0] OpLbu = 6'd36;
    localparam logic [5:0] OpLhu = 6'd37;
    localparam logic [5:0] OpLwr = 6'd38;
    localparam logic [5:0] OpSb  = 6'd40;
    localparam logic [5:0] OpSh  = 6'd41;
    localparam logic [5:0] OpSwl = 6'd42;
    localparam logic [5:0] OpSw  = 6'd43;
    localparam logic [5:0] OpSwr = 6'd46;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic [5:0]            opcode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           rt_q;
    logic [31:0]           loaddata_q;
    logic                  wr_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           wdata_q;
    logic                  fault_q;

    logic       is_load, is_store, fault, accept;
    logic [1:0] ea;
    logic [3:0] st_strb;
    logic [31:0] st_data;

    assign ea     = in_addr[1:0];
    assign accept = in_valid && (state_q == StIdle);

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (in_opcode)
            OpLb, OpLh, OpLwl, OpLw, OpLbu, OpLhu, OpLwr: is_load  = 1'b1;
            OpSb, OpSh, OpSwl, OpSw, OpSwr:               is_store = 1'b1;
            default: ;
        endcase
    end

`ifdef ADDR_EXC_EN
    assign fault = (((in_opcode == OpLh) || (in_opcode == OpLhu) || (in_opcode == OpSh)) && ea[0])
                 || (((in_opcode == OpLw) || (in_opcode == OpSw)) && (ea != 2'd0));
`else
    assign fault = 1'b0;
`endif

    // Little-endian lane placement; swl/swr write the partial word that straddles the boundary.
    always_comb begin
        st_strb = 4'b0000;
        st_data = 32'd0;
        case (in_opcode)
            OpSb: begin
                st_strb = 4'b0001 << ea;
                st_data = {4{in_rt[7:0]}};
            end
            OpSh: begin
                st_strb = ea[1] ? 4'b1100 : 4'b0011;
                st_data = {2{in_rt[15:0]}};
            end
            OpSw: begin
                st_strb = 4'b1111;
                st_data = in_rt;
            end
            OpSwl: begin
                case (ea)
                    2'd0: begin st_strb = 4'b0001; st_data = {24'd0, in_rt[31:24]}; end
                    2'd1: begin st_strb = 4'b0011; st_data = {16'd0, in_rt[31:16]}; end
                    2'd2: begin st_strb = 4'b0111; st_data = {8'd0, in_rt[31:8]};   end
                    default: begin st_strb = 4'b1111; st_data = in_rt;              end
                endcase
            end
            OpSwr: begin
                case (ea)
                    2'd0: begin st_strb = 4'b1111; st_data = in_rt;                  end
                    2'd1: begin st_strb = 4'b1110; st_data = {in_rt[23:0], 8'd0};   end
                    2'd2: begin st_strb = 4'b1100; st_data = {in_rt[15:0], 16'd0};  end
                    default: begin st_strb = 4'b1000; st_data = {in_rt[7:0], 24'd0}; end
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (fault || !(is_load || is_store)) state_d = StDone;
                    else                                 state_d = StReq;
                end
            end
            StReq:  if (data_addr_ok) state_d = StWait;
            StWait: if (data_data_ok) state_d = StDone;
            StDone: if (out_ready)    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            opcode_q   <= 6'd0;
            addr_q     <= '0;
            rt_q       <= 32'd0;
            loaddata_q <= 32'd0;
            wr_q       <= 1'b0;
            wstrb_q    <= 4'b0000;
            wdata_q    <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opcode_q   <= in_opcode;
                addr_q     <= in_addr;
                rt_q       <= in_rt;
                loaddata_q <= 32'd0;
                wr_q       <= is_store && !fault;
                wstrb_q    <= (is_store && !fault) ? st_strb : 4'b0000;
                wdata_q    <= (is_store && !fault) ? st_data : 32'd0;
                fault_q    <= fault;
            end else if ((state_q == StWait) && data_data_ok && !wr_q) begin
                loaddata_q <= data_rdata;
            end
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign data_req     = (state_q == StReq);
    assign data_wr      = wr_q;
    assign data_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign data_wstrb   = wstrb_q;
    assign data_wdata   = wdata_q;
    assign out_valid    = (state_q == StDone);
    assign out_opcode   = opcode_q;
    assign out_ea       = addr_q[1:0];
    assign out_regdata  = rt_q;
    assign out_loaddata = loaddata_q;
`ifdef ADDR_EXC_EN
    assign out_adel_ades = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table driven through a small memory responder,
// expected results queued at issue and compared when out_valid appears.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [31:0] in_addr;
    logic [31:0] in_rt;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [1:0]  out_ea;
    logic [31:0] out_regdata;
    logic [31:0] out_loaddata;
`ifdef ADDR_EXC_EN
    logic        out_adel_ades;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_addr      (in_addr),
        .in_rt        (in_rt),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_ea       (out_ea),
        .out_regdata  (out_regdata),
`ifdef ADDR_EXC_EN
        .out_adel_ades(out_adel_ades),
`endif
        .out_loaddata (out_loaddata)
    );

    typedef struct packed {
        logic [5:0]  opcode;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic [3:0]  stall;    // cycles before addr_ok
        logic [3:0]  waitc;    // cycles in WAIT before data_ok
        logic [3:0]  hold;     // cycles out_ready held low
        logic        mem;
        logic        wr;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        logic        exp_fault;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t sb_q[$];
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                                input logic [31:0] rd, input int st, input int wt, input int hd,
                                input logic m, input logic w, input logic [31:0] ea,
                                input logic [3:0] s, input logic [31:0] wd, input logic [31:0] ld);
        vec_t v;
        v.opcode = op; v.addr = a; v.rt = rt; v.rdata = rd;
        v.stall = 4'(st); v.waitc = 4'(wt); v.hold = 4'(hd);
        v.mem = m; v.wr = w; v.exp_addr = ea; v.exp_strb = s; v.exp_wdata = wd; v.exp_load = ld;
        v.exp_fault = 1'b0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   cyc;
        int   n;
        int   lat;
        @(negedge clk);
        in_valid = 1'b1; in_opcode = v.opcode; in_addr = v.addr; in_rt = v.rt;
        sb_q.push_back(v);
        @(negedge clk);
        in_valid = 1'b0; in_opcode = 6'd0; in_addr = 32'hFFFF_FFFF; in_rt = 32'h5A5A_5A5A;
        cyc = 1;
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        if (v.mem) begin
            n = 0;
            while (!data_req && n < 20) begin @(negedge clk); cyc++; n++; end
            chk("data_req", {31'd0, data_req}, 32'd1);
            for (int i = 0; i <= int'(v.stall); i++) begin
                if (i > 0) begin @(negedge clk); cyc++; end
                chk("req_held", {31'd0, data_req}, 32'd1);
                chk("data_wr", {31'd0, data_wr}, {31'd0, v.wr});
                chk("data_addr", data_addr, v.exp_addr);
                chk("data_wstrb", {28'd0, data_wstrb}, {28'd0, v.exp_strb});
                if (v.wr) chk("data_wdata", data_wdata, v.exp_wdata);
            end
            data_addr_ok = 1'b1;
            @(negedge clk); cyc++;
            data_addr_ok = 1'b0;
            chk("wait_no_req", {31'd0, data_req}, 32'd0);
            repeat (int'(v.waitc)) begin @(negedge clk); cyc++; end
            data_rdata = v.rdata; data_data_ok = 1'b1;
            @(negedge clk); cyc++;
            data_data_ok = 1'b0; data_rdata = $urandom;
            lat = 3 + int'(v.stall) + int'(v.waitc);
        end else begin
            chk("nonmem_no_req", {31'd0, data_req}, 32'd0);
            lat = 1;
        end
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); cyc++; n++; end
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("latency", cyc, lat);
        e = sb_q.pop_front();
        chk("out_opcode", {26'd0, out_opcode}, {26'd0, e.opcode});
        chk("out_ea", {30'd0, out_ea}, {30'd0, e.addr[1:0]});
        chk("out_regdata", out_regdata, e.rt);
        chk("out_loaddata", out_loaddata, e.exp_load);
`ifdef ADDR_EXC_EN
        chk("out_adel_ades", {31'd0, out_adel_ades}, {31'd0, e.exp_fault});
`endif
        repeat (int'(v.hold)) begin
            @(negedge clk);
            chk("valid_held", {31'd0, out_valid}, 32'd1);
            chk("load_held", out_loaddata, e.exp_load);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", {31'd0, out_valid}, 32'd0);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
`ifdef ADDR_EXC_EN
        vec_t f;
`endif
        //          op     addr         rt            rdata        st wt hd m  w  exp_addr     strb     wdata         load
        vecs[0]  = mk(6'd43, 32'h1004, 32'hDEADBEEF, 32'h0,       0, 0, 0, 1, 1, 32'h1004, 4'b1111, 32'hDEADBEEF, 32'h0);
        vecs[1]  = mk(6'd32, 32'h2003, 32'h0,        32'h80112233, 0, 4, 3, 1, 0, 32'h2000, 4'b0000, 32'h0,        32'h80112233);
        vecs[2]  = mk(6'd42, 32'h11,   32'hAABBCCDD, 32'h0,       0, 0, 0, 1, 1, 32'h10,   4'b0011, 32'h0000AABB, 32'h0);
        vecs[3]  = mk(6'd46, 32'h11,   32'hAABBCCDD, 32'h0,       0, 0, 0, 1, 1, 32'h10,   4'b1110, 32'hBBCCDD00, 32'h0);
        vecs[4]  = mk(6'd9,  32'h1234, 32'h77777777, 32'h0,       0, 0, 1, 0, 0, 32'h0,    4'b0000, 32'h0,        32'h0);
        vecs[5]  = mk(6'd40, 32'h22,   32'h123456A5, 32'h0,       0, 1, 0, 1, 1, 32'h20,   4'b0100, 32'hA5A5A5A5, 32'h0);
        vecs[6]  = mk(6'd41, 32'h32,   32'h1234BEEF, 32'h0,       0, 0, 0, 1, 1, 32'h30,   4'b1100, 32'hBEEFBEEF, 32'h0);
        vecs[7]  = mk(6'd37, 32'h40,   32'h0,        32'hCAFEF00D, 2, 1, 0, 1, 0, 32'h40,   4'b0000, 32'h0,        32'hCAFEF00D);
        vecs[8]  = mk(6'd42, 32'h7,    32'h11223344, 32'h0,       0, 0, 0, 1, 1, 32'h4,    4'b1111, 32'h11223344, 32'h0);
        vecs[9]  = mk(6'd46, 32'h7,    32'h11223344, 32'h0,       1, 0, 0, 1, 1, 32'h4,    4'b1000, 32'h44000000, 32'h0);
        vecs[10] = mk(6'd34, 32'h52,   32'hAAAA5555, 32'h01020304, 0, 2, 0, 1, 0, 32'h50,   4'b0000, 32'h0,        32'h01020304);

        resetn = 1'b1; in_valid = 1'b0; in_opcode = 6'd0; in_addr = 32'd0; in_rt = 32'd0;
        data_addr_ok = 1'b0; data_rdata = 32'd0; data_data_ok = 1'b0; out_ready = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_data_req", {31'd0, data_req}, 32'd0);
        chk("rst_data_wr", {31'd0, data_wr}, 32'd0);
        chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_loaddata", out_loaddata, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

`ifdef ADDR_EXC_EN
        f = mk(6'd35, 32'h1002, 32'h13572468, 32'h0, 0, 0, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0);
        f.exp_fault = 1'b1;
        run_vec(f);
`endif

        // Reset while waiting for the store ack; a late ack must not resurrect the transaction.
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 6'd43; in_addr = 32'h300; in_rt = 32'h0BADF00D;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_req", {31'd0, data_req}, 32'd1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk("mid_wait_wstrb", {28'd0, data_wstrb}, 32'hF);
        #2 resetn = 1'b0;
        #1;
        chk("async_req", {31'd0, data_req}, 32'd0);
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_wstrb", {28'd0, data_wstrb}, 32'd0);
        chk("async_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        data_data_ok = 1'b1; data_rdata = 32'h99999999;
        @(negedge clk);
        data_data_ok = 1'b0;
        chk("stray_ok_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("stray_ok_valid2", {31'd0, out_valid}, 32'd0);
        chk("stray_ok_ready", {31'd0, in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
